// File: rtl/tri_inside.sv
// tri_inside: inside-outside test for one candidate hit point against one
// triangle. The three edge tests run one after another through a single
// subtract / cross-product / dot-product pipeline. The result goes into a
// one-entry output register read through an empty/rd_en handshake.
//
// Handshake: upstream data is first-word-fall-through. The pop strobe
// in_rd_en is high only in IDLE while in_empty=0, and the data is
// captured on that same edge. Downstream, out_empty=0 means out_p/out_hit
// are valid. The consumer pops with out_rd_en. A pop and a new load on the
// same edge keep out_empty=0 and replace the data.
module tri_inside #(
    parameter int Q_BITS = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic signed [31:0] p          [2:0],
    input  logic signed [31:0] v0         [2:0],
    input  logic signed [31:0] v1         [2:0],
    input  logic signed [31:0] v2         [2:0],
    input  logic signed [31:0] tri_normal [2:0],
    input  logic               in_empty,
    output logic               in_rd_en,
    output logic signed [31:0] out_p      [2:0],
    output logic               out_hit,
    output logic               out_empty,
    input  logic               out_rd_en,
    output logic [2:0]         dbg_state
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SUB   = 3'd1,
        CROSS = 3'd2,
        DOT   = 3'd3,
        OUT   = 3'd4
    } state_t;

    state_t             state_q;
    logic [1:0]         k_q;
    logic [2:0]         pass_q;
    logic signed [31:0] p_q   [2:0];
    logic signed [31:0] v0_q  [2:0];
    logic signed [31:0] v1_q  [2:0];
    logic signed [31:0] v2_q  [2:0];
    logic signed [31:0] n_q   [2:0];
    logic signed [31:0] e_q   [2:0];
    logic signed [31:0] d_q   [2:0];
    logic signed [31:0] c_q   [2:0];
    logic signed [31:0] out_p_q [2:0];
    logic               out_hit_q;
    logic               out_empty_q;

    logic signed [31:0] a_sel [2:0];
    logic signed [31:0] b_sel [2:0];
    logic signed [31:0] e_d   [2:0];
    logic signed [31:0] d_d   [2:0];
    logic signed [63:0] cr_full [2:0];
    logic signed [31:0] c_d   [2:0];
    logic signed [65:0] dot_s;
    logic               pass_d;
    logic               load;

    // Full 64-bit product of two signed 32-bit operands.
    function automatic logic signed [63:0] smul(input logic signed [31:0] x,
                                                input logic signed [31:0] y);
        logic signed [63:0] xx;
        logic signed [63:0] yy;
        xx = {{32{x[31]}}, x};
        yy = {{32{y[31]}}, y};
        return xx * yy;
    endfunction

    // Sign-extend a 64-bit product into the 66-bit dot accumulator.
    function automatic logic signed [65:0] sext66(input logic signed [63:0] x);
        return {{2{x[63]}}, x};
    endfunction

    // Edge k walks (v0,v1), (v1,v2), (v2,v0); then e = b - a and d = P - a.
    always_comb begin
        a_sel = v2_q;
        b_sel = v0_q;
        case (k_q)
            2'd0: begin
                a_sel = v0_q;
                b_sel = v1_q;
            end
            2'd1: begin
                a_sel = v1_q;
                b_sel = v2_q;
            end
            default: ;
        endcase
        for (int i = 0; i < 3; i++) begin
            e_d[i] = b_sel[i] - a_sel[i];
            d_d[i] = p_q[i] - a_sel[i];
        end
    end

    // Cross product e x d: each component is rescaled back to Q format and truncated to 32 bits.
    always_comb begin
        cr_full[0] = smul(e_q[1], d_q[2]) - smul(e_q[2], d_q[1]);
        cr_full[1] = smul(e_q[2], d_q[0]) - smul(e_q[0], d_q[2]);
        cr_full[2] = smul(e_q[0], d_q[1]) - smul(e_q[1], d_q[0]);
        for (int i = 0; i < 3; i++) begin
            c_d[i] = 32'(cr_full[i] >>> Q_BITS);
        end
    end

    // Dot product c.n in full width: only the sign matters, and zero counts as inside.
    always_comb begin
        dot_s  = sext66(smul(c_q[0], n_q[0]))
               + sext66(smul(c_q[1], n_q[1]))
               + sext66(smul(c_q[2], n_q[2]));
        pass_d = (dot_s >= 66'sd0);
    end

    // The pop strobe never fires while reset is held, so nothing is lost during reset.
    assign in_rd_en = (state_q == IDLE) && !in_empty && !reset;
    assign load     = (state_q == OUT) && (out_empty_q || out_rd_en);

    // Sequencer plus the output register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            k_q         <= 2'd0;
            pass_q      <= 3'd0;
            out_hit_q   <= 1'b0;
            out_empty_q <= 1'b1;
            for (int i = 0; i < 3; i++) begin
                p_q[i]     <= '0;
                v0_q[i]    <= '0;
                v1_q[i]    <= '0;
                v2_q[i]    <= '0;
                n_q[i]     <= '0;
                e_q[i]     <= '0;
                d_q[i]     <= '0;
                c_q[i]     <= '0;
                out_p_q[i] <= '0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (!in_empty) begin
                        p_q     <= p;
                        v0_q    <= v0;
                        v1_q    <= v1;
                        v2_q    <= v2;
                        n_q     <= tri_normal;
                        k_q     <= 2'd0;
                        state_q <= SUB;
                    end
                end
                SUB: begin
                    e_q     <= e_d;
                    d_q     <= d_d;
                    state_q <= CROSS;
                end
                CROSS: begin
                    c_q     <= c_d;
                    state_q <= DOT;
                end
                DOT: begin
                    pass_q[k_q] <= pass_d;
                    if (k_q == 2'd2) begin
                        state_q <= OUT;
                    end else begin
                        k_q     <= k_q + 2'd1;
                        state_q <= SUB;
                    end
                end
                OUT: begin
                    if (load) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase

            if (load) begin
                out_p_q     <= p_q;
                out_hit_q   <= &pass_q;
                out_empty_q <= 1'b0;
            end else if (out_rd_en && !out_empty_q) begin
                out_empty_q <= 1'b1;
            end
        end
    end

    assign out_p     = out_p_q;
    assign out_hit   = out_hit_q;
    assign out_empty = out_empty_q;
    assign dbg_state = state_q;

endmodule
